// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the fetch stage.
// Reset vector, instruction size and handshake widths.
package instruction_fetch_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          SYN_W       = 1;
    localparam int          ACK_W       = 1;

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Fetch address register: reset vector, redirect load,
// sequential increment, otherwise hold.
module fetch_pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] load_addr,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] addr_d;
    logic [AW-1:0] addr_q;

    // Redirect beats increment; increment wraps naturally at AW bits.
    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_addr;
        end else if (inc) begin
            addr_d = addr_q + AW'(INSTR_BYTES);
        end
    end

    // Address state, async reset to the reset vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= AW'(RESET_PC);
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one-word requests, registers the
// returned instruction and its PC toward decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int IWIDTH       = 32,
    parameter int AWIDTH_INSTR = 32,
    parameter int PC_WIDTH     = 32
) (
    input  logic                    f_clk,
    input  logic                    f_rst,
    input  logic [IWIDTH-1:0]       f_i_instr,
    input  logic                    f_i_ack,
    output logic [AWIDTH_INSTR-1:0] f_o_addr_instr,
    output logic                    f_o_syn,
    output logic [IWIDTH-1:0]       f_o_instr,
    output logic [PC_WIDTH-1:0]     f_pc,
    input  logic                    f_change_pc,
    input  logic [PC_WIDTH-1:0]     f_alu_pc_value,
    input  logic                    f_i_stall,
    output logic                    f_o_stall,
    input  logic                    f_i_ce,
    output logic                    f_o_ce,
    input  logic                    f_i_flush,
    output logic                    f_o_flush
);

    logic                accept;
    logic [IWIDTH-1:0]   instr_d, instr_q;
    logic [PC_WIDTH-1:0] pc_d, pc_q;
    logic                ce_d, ce_q;
    logic                flush_d, flush_q;

    // Requests are suppressed by anything that would discard the ack.
    assign f_o_syn   = f_i_ce & ~f_i_stall & ~f_i_flush & ~f_change_pc;
    assign f_o_stall = f_i_stall | (f_o_syn & ~f_i_ack);
    assign accept    = f_o_syn & f_i_ack;

    fetch_pc_reg #(
        .AW(AWIDTH_INSTR)
    ) u_pc_reg (
        .clk      (f_clk),
        .rst_n    (f_rst),
        .load     (f_change_pc),
        .inc      (accept),
        .load_addr(AWIDTH_INSTR'(f_alu_pc_value)),
        .addr     (f_o_addr_instr)
    );

    // Output bundle: redirect/flush kill the strobe, stall freezes it.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        ce_d    = ce_q;
        flush_d = f_i_flush;
        if (f_change_pc || f_i_flush) begin
            ce_d = 1'b0;
        end else if (f_i_stall) begin
            ce_d = ce_q;
        end else if (accept) begin
            instr_d = f_i_instr;
            pc_d    = PC_WIDTH'(f_o_addr_instr);
            ce_d    = 1'b1;
        end else begin
            ce_d = 1'b0;
        end
    end

    // Output registers toward decode.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            instr_q <= '0;
            pc_q    <= '0;
            ce_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            ce_q    <= ce_d;
            flush_q <= flush_d;
        end
    end

    assign f_o_instr = instr_q;
    assign f_pc      = pc_q;
    assign f_o_ce    = ce_q;
    assign f_o_flush = flush_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with a
// behavioural reference model and random stimulus.
module tb_instruction_fetch;

    logic        f_clk = 1'b0;
    logic        f_rst = 1'b0;
    logic [31:0] f_i_instr = '0;
    logic        f_i_ack = 1'b0;
    logic [31:0] f_o_addr_instr;
    logic        f_o_syn;
    logic [31:0] f_o_instr;
    logic [31:0] f_pc;
    logic        f_change_pc = 1'b0;
    logic [31:0] f_alu_pc_value = '0;
    logic        f_i_stall = 1'b0;
    logic        f_o_stall;
    logic        f_i_ce = 1'b0;
    logic        f_o_ce;
    logic        f_i_flush = 1'b0;
    logic        f_o_flush;

    instruction_fetch dut (
        .f_clk         (f_clk),
        .f_rst         (f_rst),
        .f_i_instr     (f_i_instr),
        .f_i_ack       (f_i_ack),
        .f_o_addr_instr(f_o_addr_instr),
        .f_o_syn       (f_o_syn),
        .f_o_instr     (f_o_instr),
        .f_pc          (f_pc),
        .f_change_pc   (f_change_pc),
        .f_alu_pc_value(f_alu_pc_value),
        .f_i_stall     (f_i_stall),
        .f_o_stall     (f_o_stall),
        .f_i_ce        (f_i_ce),
        .f_o_ce        (f_o_ce),
        .f_i_flush     (f_i_flush),
        .f_o_flush     (f_o_flush)
    );

    always #5 f_clk = ~f_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ce;
        logic        flush;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference state: what the stage should hold after the last edge.
    logic [31:0] m_addr  = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc    = '0;
    logic        m_ce    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_addr  = '0;
        m_instr = '0;
        m_pc    = '0;
        m_ce    = 1'b0;
    endtask

    // One cycle of stimulus: drive, check combinational outputs,
    // advance the model and queue the expected registered state.
    task automatic step(input logic ce, input logic ack,
                        input logic [31:0] ins, input logic st,
                        input logic fl, input logic ch,
                        input logic [31:0] tgt);
        logic req;
        logic take;
        exp_t e;
        @(negedge f_clk);
        f_i_ce         = ce;
        f_i_ack        = ack;
        f_i_instr      = ins;
        f_i_stall      = st;
        f_i_flush      = fl;
        f_change_pc    = ch;
        f_alu_pc_value = tgt;
        #1;
        // A request goes out only when nothing would throw it away.
        req  = ce && !st && !fl && !ch;
        take = req && ack;
        chk("syn", {31'd0, f_o_syn}, {31'd0, req});
        chk("stall", {31'd0, f_o_stall}, {31'd0, st || (req && !ack)});
        if (ch) begin
            m_addr = tgt;
            m_ce   = 1'b0;
        end else if (fl) begin
            m_ce = 1'b0;
        end else if (st) begin
            m_ce = m_ce;
        end else if (take) begin
            m_instr = ins;
            m_pc    = m_addr;
            m_addr  = m_addr + 32'd4;
            m_ce    = 1'b1;
        end else begin
            m_ce = 1'b0;
        end
        e.addr  = m_addr;
        e.instr = m_instr;
        e.pc    = m_pc;
        e.ce    = m_ce;
        e.flush = fl;
        exp_q.push_back(e);
    endtask

    // Monitor: after every edge, compare DUT state to the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge f_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("addr", f_o_addr_instr, e.addr);
                chk("instr", f_o_instr, e.instr);
                chk("pc", f_pc, e.pc);
                chk("ce", {31'd0, f_o_ce}, {31'd0, e.ce});
                chk("flush", {31'd0, f_o_flush}, {31'd0, e.flush});
            end
        end
    end

    task automatic after_edge();
        @(posedge f_clk);
        #2;
    endtask

    initial begin
        // Reset for two cycles.
        f_rst = 1'b0;
        repeat (2) @(posedge f_clk);
        #1;
        chk("rst_addr", f_o_addr_instr, 32'h0);
        chk("rst_instr", f_o_instr, 32'h0);
        chk("rst_pc", f_pc, 32'h0);
        chk("rst_ce", {31'd0, f_o_ce}, 32'd0);
        chk("rst_flush", {31'd0, f_o_flush}, 32'd0);
        @(negedge f_clk);
        f_rst = 1'b1;
        model_reset();

        // Requesting with no ack stalls.
        step(1, 0, 32'h0, 0, 0, 0, 32'h0);

        // Three accepts separated by idle cycles.
        step(1, 1, 32'hA0A0A0A0, 0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
        step(1, 1, 32'hB1B1B1B1, 0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
        step(1, 1, 32'hC2C2C2C2, 0, 0, 0, 32'h0);
        after_edge();
        chk("abc_pc", f_pc, 32'h8);
        chk("abc_addr", f_o_addr_instr, 32'hC);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);

        // Stall for three cycles, then accept D.
        repeat (3) step(1, 1, 32'hDEADBEEF, 1, 0, 0, 32'h0);
        after_edge();
        chk("stall_addr", f_o_addr_instr, 32'hC);
        chk("stall_instr", f_o_instr, 32'hC2C2C2C2);
        step(1, 1, 32'hD3D3D3D3, 0, 0, 0, 32'h0);
        after_edge();
        chk("d_pc", f_pc, 32'hC);
        chk("d_addr", f_o_addr_instr, 32'h10);

        // Redirect with a stray ack that must be ignored.
        step(0, 1, 32'h12345678, 0, 0, 1, 32'h100);
        after_edge();
        chk("redir_addr", f_o_addr_instr, 32'h100);
        chk("redir_instr", f_o_instr, 32'hD3D3D3D3);

        // Flush two cycles, then E and F.
        repeat (2) step(1, 1, 32'h55555555, 0, 1, 0, 32'h0);
        step(1, 1, 32'hE4E4E4E4, 0, 0, 0, 32'h0);
        after_edge();
        chk("e_pc", f_pc, 32'h100);
        step(1, 1, 32'hF5F5F5F5, 0, 0, 0, 32'h0);
        after_edge();
        chk("f_pc", f_pc, 32'h104);
        chk("f_addr", f_o_addr_instr, 32'h108);

        // Address wrap.
        step(1, 0, 32'h0, 0, 0, 1, 32'hFFFFFFFC);
        step(1, 1, 32'h77777777, 0, 0, 0, 32'h0);
        after_edge();
        chk("wrap_addr", f_o_addr_instr, 32'h0);
        chk("wrap_pc", f_pc, 32'hFFFFFFFC);

        // Redirect, flush and stall together.
        step(1, 1, 32'h66666666, 1, 1, 1, 32'h200);
        after_edge();
        chk("prio_addr", f_o_addr_instr, 32'h200);
        chk("prio_ce", {31'd0, f_o_ce}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom % 2, $urandom,
                 ($urandom % 8) == 0, ($urandom % 10) == 0,
                 ($urandom % 12) == 0, $urandom & 32'hFFFFFFFC);
        end

        // Reset asserted in the middle of a pending request.
        repeat (2) @(posedge f_clk);
        @(negedge f_clk);
        f_i_ce    = 1'b1;
        f_i_ack   = 1'b0;
        f_i_stall = 1'b0;
        f_i_flush = 1'b0;
        f_change_pc = 1'b0;
        #2;
        f_rst = 1'b0;
        #1;
        chk("mid_rst_addr", f_o_addr_instr, 32'h0);
        chk("mid_rst_ce", {31'd0, f_o_ce}, 32'd0);
        chk("mid_rst_pc", f_pc, 32'h0);
        @(negedge f_clk);
        f_rst = 1'b1;
        model_reset();
        step(1, 1, 32'h99999999, 0, 0, 0, 32'h0);
        after_edge();
        chk("post_rst_pc", f_pc, 32'h0);
        chk("post_rst_addr", f_o_addr_instr, 32'h4);

        repeat (2) @(posedge f_clk);
        #3;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
